bus_seq_ctrl: RTL and testbench
===============================

BUS_SEQ_CTRL -- requirements
Module: bus_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, maximum ACCESS-state cycles before abort (legal 2..1023).
REQ-002 Parameter TURN_CYC, default 1, bus-turnaround idle cycles after a write (legal 1..7).
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  in  1  reset, synchronous to clk_i, active-high.
REQ-005 req_valid_i  in  1  core request valid; req_ready_o  out  1  request accepted when both high.
REQ-006 req_we_i  in  1  1 = write; req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 req_addr_i  in  16  byte address; req_wdata_i  in  32  write data, LSB-aligned.
REQ-008 resp_valid_o  out  1  one-cycle response pulse; resp_err_o  out  1  error flag; resp_rdata_o  out  32  read data.
REQ-009 bus_en_o, bus_we_o  out  1 each; bus_size_o  out  2; bus_addr_o  out  16; all to pad ring.
REQ-010 bus_data_drv_b  out  32  pad output data; bus_data_recv_b  in  32  pad receive data.
REQ-011 dbus_o_en_b  out  1  pad driver enable (1 = drive); dbus_i_en_b  out  1  pad receiver enable (1 = receive).
REQ-012 bus_rdy_i  in  1  external device ready, already synchronised.

Function
REQ-013 FSM states IDLE, SETUP, ACCESS, TURN; req_ready_o = 1 only in IDLE.
REQ-014 IDLE, req_valid_i=1, legal size/alignment: latch we/size/addr/wdata, go SETUP.
REQ-015 Illegal: size 11, half with addr[0]=1, word with addr[1:0]!=0; stay IDLE, next cycle resp_valid_o=1, resp_err_o=1, resp_rdata_o=0; no bus activity.
REQ-016 SETUP (exactly 1 cycle): bus_addr_o/bus_size_o/bus_we_o driven from latched values, bus_en_o=0; go ACCESS.
REQ-017 ACCESS: bus_en_o=1, address/size/we held stable; cycle counter starts at 0, increments each ACCESS cycle.
REQ-018 ACCESS, bus_rdy_i=1: read -> capture lane data, go IDLE; write -> go TURN; resp_valid_o=1, resp_err_o=0 next cycle.
REQ-019 ACCESS, bus_rdy_i=0 with counter = TIMEOUT_CYC-1: abort; resp_valid_o=1, resp_err_o=1, resp_rdata_o=0 next cycle; read -> IDLE, write -> TURN.
REQ-020 TURN: bus_en_o=0, dbus_o_en_b=0, dbus_i_en_b=0 for exactly TURN_CYC cycles, then IDLE.
REQ-021 Write drive: dbus_o_en_b=1 in SETUP and ACCESS only; dbus_i_en_b=0 from SETUP through end of TURN.
REQ-022 Read and IDLE: dbus_o_en_b=0, dbus_i_en_b=1.
REQ-023 dbus_o_en_b and dbus_i_en_b never both 1; at least one cycle with both 0 between driver-off and receiver-on.
REQ-024 Write lanes: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word -> wdata; bus_data_drv_b=0 when dbus_o_en_b=0.
REQ-025 Read lanes: byte -> zero-extend recv[8*a+7:8*a], a=addr[1:0]; half -> zero-extend recv[16*a1+15:16*a1], a1=addr[1]; word -> recv.
REQ-026 resp_valid_o is registered, high exactly one cycle per accepted request; resp_rdata_o/resp_err_o valid only while resp_valid_o=1, else 0.
REQ-027 Read latency, rdy already high: accept edge N -> resp_valid_o high in cycle N+3, req_ready_o high same cycle (back-to-back accepted).
REQ-028 bus_rdy_i ignored outside ACCESS; req_valid_i ignored outside IDLE.

Reset
REQ-029 reset_i=1 at an edge: state IDLE, counters 0, latched request cleared, regardless of current state.
REQ-030 Reset outputs: bus_en_o=0, bus_we_o=0, bus_size_o=0, bus_addr_o=0, bus_data_drv_b=0, dbus_o_en_b=0, dbus_i_en_b=1, req_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0.
REQ-031 Reset mid-transaction produces no response pulse for the aborted request.

Verification
REQ-032 Word read addr 0x0010, rdy high on first ACCESS cycle, recv=0xDEADBEEF -> resp_valid_o at accept+3, rdata 0xDEADBEEF, err 0.
REQ-033 Byte write addr 0x0003, wdata 0x000000A5 -> drv 0xA5A5A5A5, o_en=1 in SETUP+ACCESS, TURN_CYC cycles both enables 0, then i_en=1.
REQ-034 Half read addr 0x0002, recv=0x12345678 -> rdata 0x00001234; byte read addr 0x0001 -> 0x00000056.
REQ-035 TIMEOUT_CYC=4, rdy held low -> bus_en_o high exactly 4 cycles, resp_err_o=1, rdata 0.
REQ-036 Word request addr 0x0002, and size 11 -> immediate err response, bus_en_o never asserted.
REQ-037 reset_i pulsed during write ACCESS -> next cycle all REQ-030 values, no resp_valid_o; subsequent read completes normally.

Source files
------------

// File: rtl/bus_seq_ctrl.sv
// bus_seq_ctrl: runs one core request at a time on an external pad bus.
// Each request goes through address setup, a data phase that waits for the
// device (bounded by a timeout), and a turnaround gap after writes. The gap
// keeps the pad driver and the pad receiver from being enabled together.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | ready for a request; illegal requests get an error reply
// ST_SETUP  | address/size/we on the pads, bus_en low, one cycle
// ST_ACCESS | bus_en high, waiting for bus_rdy_i or the timeout
// ST_TURN   | after a write, driver and receiver both off for TURN_CYC
module bus_seq_ctrl #(
   parameter int TIMEOUT_CYC = 255,
   parameter int TURN_CYC    = 1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic [15:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic        resp_err_o,
   output logic [31:0] resp_rdata_o,
   output logic        bus_en_o,
   output logic        bus_we_o,
   output logic [1:0]  bus_size_o,
   output logic [15:0] bus_addr_o,
   output logic [31:0] bus_data_drv_b,
   input  logic [31:0] bus_data_recv_b,
   output logic        dbus_o_en_b,
   output logic        dbus_i_en_b,
   input  logic        bus_rdy_i
);

   localparam int TMO_W  = 10;
   localparam int TURN_W = 3;

   // Both timers count down to zero; terminal count ends the phase.
   localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_TURN   = 2'd3
   } state_t;

   state_t             state;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [TURN_W-1:0]  turn_cnt;
   logic               acc_done;
   logic [31:0]        rd_data;

   // Size 11 is never legal; halves and words must be naturally aligned.
   function automatic logic req_legal(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   req_legal = 1'b1;
         2'b01:   req_legal = ~a[0];
         2'b10:   req_legal = (a == 2'b00);
         default: req_legal = 1'b0;
      endcase
   endfunction

   // Narrow writes are copied to every lane so the device can take any lane.
   function automatic logic [31:0] wr_lanes(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   wr_lanes = {4{d[7:0]}};
         2'b01:   wr_lanes = {2{d[15:0]}};
         default: wr_lanes = d;
      endcase
   endfunction

   // Select the addressed read lane and zero-extend it.
   always_comb begin
      rd_data = '0;
      case (bus_size_o)
         2'b00: begin
            case (bus_addr_o[1:0])
               2'd0:    rd_data[7:0] = bus_data_recv_b[7:0];
               2'd1:    rd_data[7:0] = bus_data_recv_b[15:8];
               2'd2:    rd_data[7:0] = bus_data_recv_b[23:16];
               default: rd_data[7:0] = bus_data_recv_b[31:24];
            endcase
         end
         2'b01:   rd_data[15:0] = bus_addr_o[1] ? bus_data_recv_b[31:16] : bus_data_recv_b[15:0];
         default: rd_data = bus_data_recv_b;
      endcase
   end

   // The data phase ends when the device is ready or the timer runs out.
   assign acc_done = bus_rdy_i | (tmo_cnt == '0);

   // Sequencer: state, timers and all registered outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state          <= ST_IDLE;
         tmo_cnt        <= '0;
         turn_cnt       <= '0;
         req_ready_o    <= 1'b1;
         resp_valid_o   <= 1'b0;
         resp_err_o     <= 1'b0;
         resp_rdata_o   <= '0;
         bus_en_o       <= 1'b0;
         bus_we_o       <= 1'b0;
         bus_size_o     <= '0;
         bus_addr_o     <= '0;
         bus_data_drv_b <= '0;
         dbus_o_en_b    <= 1'b0;
         dbus_i_en_b    <= 1'b1;
      end else begin
         resp_valid_o <= 1'b0;
         resp_err_o   <= 1'b0;
         resp_rdata_o <= '0;
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  if (req_legal(req_size_i, req_addr_i[1:0])) begin
                     state          <= ST_SETUP;
                     req_ready_o    <= 1'b0;
                     tmo_cnt        <= TMO_LOAD;
                     bus_en_o       <= 1'b0;
                     bus_we_o       <= req_we_i;
                     bus_size_o     <= req_size_i;
                     bus_addr_o     <= req_addr_i;
                     bus_data_drv_b <= req_we_i ? wr_lanes(req_size_i, req_wdata_i) : '0;
                     dbus_o_en_b    <= req_we_i;
                     dbus_i_en_b    <= ~req_we_i;
                  end else begin
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b1;
                  end
               end
            end
            ST_SETUP: begin
               state    <= ST_ACCESS;
               bus_en_o <= 1'b1;
            end
            ST_ACCESS: begin
               if (acc_done) begin
                  resp_valid_o   <= 1'b1;
                  resp_err_o     <= ~bus_rdy_i;
                  resp_rdata_o   <= (bus_rdy_i && !bus_we_o) ? rd_data : '0;
                  bus_en_o       <= 1'b0;
                  bus_data_drv_b <= '0;
                  dbus_o_en_b    <= 1'b0;
                  if (bus_we_o) begin
                     // Driver goes off now; receiver stays off through TURN.
                     state       <= ST_TURN;
                     turn_cnt    <= TURN_LOAD;
                     dbus_i_en_b <= 1'b0;
                  end else begin
                     state       <= ST_IDLE;
                     req_ready_o <= 1'b1;
                     dbus_i_en_b <= 1'b1;
                     bus_we_o    <= 1'b0;
                     bus_size_o  <= '0;
                     bus_addr_o  <= '0;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            ST_TURN: begin
               if (turn_cnt == '0) begin
                  state       <= ST_IDLE;
                  req_ready_o <= 1'b1;
                  dbus_i_en_b <= 1'b1;
                  bus_we_o    <= 1'b0;
                  bus_size_o  <= '0;
                  bus_addr_o  <= '0;
               end else begin
                  turn_cnt <= turn_cnt - 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               req_ready_o <= 1'b1;
               bus_en_o    <= 1'b0;
               dbus_o_en_b <= 1'b0;
               dbus_i_en_b <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_seq_ctrl.sv
// Bench for bus_seq_ctrl. Each request is expanded into the cycle-by-cycle
// picture the outputs must show (setup, data phase of computed length,
// turnaround, response). A compare process checks the DUT against that
// picture on every cycle. The directed requests also carry hand-computed
// literal values.
module tb_bus_seq_ctrl;

   localparam int T    = 4;
   localparam int TURN = 2;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = '0;
   logic [15:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        resp_valid_o;
   logic        resp_err_o;
   logic [31:0] resp_rdata_o;
   logic        bus_en_o;
   logic        bus_we_o;
   logic [1:0]  bus_size_o;
   logic [15:0] bus_addr_o;
   logic [31:0] bus_data_drv_b;
   logic [31:0] bus_data_recv_b = '0;
   logic        dbus_o_en_b;
   logic        dbus_i_en_b;
   logic        bus_rdy_i = 1'b0;

   bus_seq_ctrl #(.TIMEOUT_CYC(T), .TURN_CYC(TURN)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_size_i(req_size_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
      .bus_en_o(bus_en_o), .bus_we_o(bus_we_o), .bus_size_o(bus_size_o),
      .bus_addr_o(bus_addr_o), .bus_data_drv_b(bus_data_drv_b),
      .bus_data_recv_b(bus_data_recv_b),
      .dbus_o_en_b(dbus_o_en_b), .dbus_i_en_b(dbus_i_en_b),
      .bus_rdy_i(bus_rdy_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        ready;
      logic        resp_valid;
      logic        resp_err;
      logic [31:0] rdata;
      logic        bus_en;
      logic        chk_bus;
      logic        bus_we;
      logic [1:0]  bus_size;
      logic [15:0] bus_addr;
      logic [31:0] drv;
      logic        o_en;
      logic        i_en;
      logic        lit_rd_en;
      logic [31:0] lit_rd;
      logic        lit_drv_en;
      logic [31:0] lit_drv;
   } exp_t;

   exp_t exp_q[$];
   exp_t ce;
   int   checks = 0;
   int   errors = 0;

   logic        pend_v = 1'b0;
   logic        pend_err = 1'b0;
   logic [31:0] pend_rd = '0;
   logic        pend_lit_en = 1'b0;
   logic [31:0] pend_lit = '0;

   // ---------------- reference rules ----------------
   function automatic logic m_legal(input logic [1:0] size, input logic [15:0] addr);
      if (size == 2'd3) return 1'b0;
      if (size == 2'd1) return (addr % 2) == 0;
      if (size == 2'd2) return (addr % 4) == 0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_wr(input logic [1:0] size, input logic [31:0] w);
      if (size == 2'd0) return 32'(w[7:0]) * 32'h0101_0101;
      if (size == 2'd1) return 32'(w[15:0]) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] m_rd(input logic [1:0] size, input logic [15:0] addr,
                                        input logic [31:0] r);
      int a;
      a = int'(addr);
      if (size == 2'd0) return (r >> (8 * (a % 4))) & 32'h0000_00FF;
      if (size == 2'd1) return (r >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
      return r;
   endfunction

   function automatic exp_t blank_exp();
      exp_t e;
      e.ready = 1'b0; e.resp_valid = 1'b0; e.resp_err = 1'b0; e.rdata = '0;
      e.bus_en = 1'b0; e.chk_bus = 1'b0; e.bus_we = 1'b0; e.bus_size = '0;
      e.bus_addr = '0; e.drv = '0; e.o_en = 1'b0; e.i_en = 1'b0;
      e.lit_rd_en = 1'b0; e.lit_rd = '0; e.lit_drv_en = 1'b0; e.lit_drv = '0;
      return e;
   endfunction

   function automatic exp_t idle_exp();
      exp_t e;
      e = blank_exp();
      e.ready = 1'b1;
      e.i_en  = 1'b1;
      return e;
   endfunction

   function automatic exp_t reset_exp();
      exp_t e;
      e = idle_exp();
      e.chk_bus = 1'b1;
      return e;
   endfunction

   function automatic exp_t bus_exp(input logic en, input logic we, input logic [1:0] size,
                                    input logic [15:0] addr, input logic [31:0] wdata);
      exp_t e;
      e = blank_exp();
      e.bus_en = en; e.chk_bus = 1'b1;
      e.bus_we = we; e.bus_size = size; e.bus_addr = addr;
      e.drv  = we ? m_wr(size, wdata) : 32'h0;
      e.o_en = we;
      e.i_en = ~we;
      return e;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic step(input exp_t e_in);
      exp_t e;
      e = e_in;
      @(posedge clk_i);
      #1;
      if (pend_v) begin
         e.resp_valid = 1'b1;
         e.resp_err   = pend_err;
         e.rdata      = pend_rd;
         e.lit_rd_en  = pend_lit_en;
         e.lit_rd     = pend_lit;
         pend_v       = 1'b0;
         pend_lit_en  = 1'b0;
      end
      exp_q.push_back(e);
   endtask

   task automatic drive_junk();
      req_valid_i     = 1'($urandom_range(0, 1));
      req_we_i        = 1'($urandom_range(0, 1));
      req_size_i      = 2'($urandom_range(0, 3));
      req_addr_i      = 16'($urandom);
      req_wdata_i     = $urandom;
      bus_rdy_i       = 1'($urandom_range(0, 1));
      bus_data_recv_b = $urandom;
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         drive_junk();
         req_valid_i = 1'b0;
         step(idle_exp());
      end
   endtask

   // d = number of not-ready data-phase cycles before bus_rdy_i rises
   task automatic run_txn(input logic we, input logic [1:0] size, input logic [15:0] addr,
                          input logic [31:0] wdata, input int d,
                          input logic fix_recv, input logic [31:0] recv, input int reset_at,
                          input logic lit_rd_en, input logic [31:0] lit_rd,
                          input logic lit_drv_en, input logic [31:0] lit_drv);
      exp_t e;
      int   n;
      drive_junk();
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_size_i  = size;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      if (!m_legal(size, addr)) begin
         pend_v = 1'b1; pend_err = 1'b1; pend_rd = '0;
         pend_lit_en = lit_rd_en; pend_lit = lit_rd;
         step(idle_exp());
         req_valid_i = 1'b0;
         return;
      end
      e = bus_exp(1'b0, we, size, addr, wdata);
      e.lit_drv_en = lit_drv_en; e.lit_drv = lit_drv;
      step(e);
      drive_junk();
      n = (d < T) ? d + 1 : T;
      for (int k = 0; k < n; k++) begin
         e = bus_exp(1'b1, we, size, addr, wdata);
         e.lit_drv_en = lit_drv_en; e.lit_drv = lit_drv;
         step(e);
         drive_junk();
         if (k == reset_at) begin
            reset_i = 1'b1;
            step(reset_exp());
            reset_i     = 1'b0;
            req_valid_i = 1'b0;
            return;
         end
         bus_rdy_i = (k == d);
         if (fix_recv) bus_data_recv_b = recv;
         if (k == n - 1) begin
            pend_v      = 1'b1;
            pend_err    = (d >= T);
            pend_rd     = (d < T && !we) ? m_rd(size, addr, bus_data_recv_b) : 32'h0;
            pend_lit_en = lit_rd_en;
            pend_lit    = lit_rd;
         end
      end
      if (we) begin
         for (int j = 0; j < TURN; j++) begin
            e = blank_exp();
            step(e);
            drive_junk();
         end
      end
      step(idle_exp());
      req_valid_i = 1'b0;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Compare every cycle against the expected picture for that cycle.
   always @(negedge clk_i) begin
      if (exp_q.size() != 0) begin
         ce = exp_q.pop_front();
         chk("req_ready",  32'(req_ready_o),  32'(ce.ready));
         chk("resp_valid", 32'(resp_valid_o), 32'(ce.resp_valid));
         chk("resp_err",   32'(resp_err_o),   32'(ce.resp_err));
         chk("resp_rdata", resp_rdata_o,      ce.rdata);
         chk("bus_en",     32'(bus_en_o),     32'(ce.bus_en));
         chk("drv",        bus_data_drv_b,    ce.drv);
         chk("o_en",       32'(dbus_o_en_b),  32'(ce.o_en));
         chk("i_en",       32'(dbus_i_en_b),  32'(ce.i_en));
         chk("enable_overlap", 32'(dbus_o_en_b & dbus_i_en_b), 32'h0);
         if (ce.chk_bus) begin
            chk("bus_we",   32'(bus_we_o),   32'(ce.bus_we));
            chk("bus_size", 32'(bus_size_o), 32'(ce.bus_size));
            chk("bus_addr", 32'(bus_addr_o), 32'(ce.bus_addr));
         end
         if (ce.lit_rd_en)  chk("literal_rdata", resp_rdata_o, ce.lit_rd);
         if (ce.lit_drv_en) chk("literal_drv", bus_data_drv_b, ce.lit_drv);
      end
   end

   initial begin
      logic        we;
      logic [1:0]  size;
      logic [15:0] addr;
      int          d;
      int          n;
      int          rst_at;

      repeat (3) step(reset_exp());
      reset_i = 1'b0;
      step(reset_exp());

      // word read 0x0010, ready on first data cycle
      run_txn(1'b0, 2'b10, 16'h0010, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, -1,
              1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
      // byte write 0x0003 replicated on all lanes
      run_txn(1'b1, 2'b00, 16'h0003, 32'h0000_00A5, 1, 1'b0, 32'h0, -1,
              1'b1, 32'h0, 1'b1, 32'hA5A5_A5A5);
      // half read 0x0002 and byte read 0x0001
      run_txn(1'b0, 2'b01, 16'h0002, 32'h0, 2, 1'b1, 32'h1234_5678, -1,
              1'b1, 32'h0000_1234, 1'b0, 32'h0);
      run_txn(1'b0, 2'b00, 16'h0001, 32'h0, 0, 1'b1, 32'h1234_5678, -1,
              1'b1, 32'h0000_0056, 1'b0, 32'h0);
      idle_gap(1);
      // timeout: device never ready
      run_txn(1'b0, 2'b10, 16'h0100, 32'h0, 50, 1'b1, 32'hFFFF_FFFF, -1,
              1'b1, 32'h0, 1'b0, 32'h0);
      // write timeout goes through turnaround
      run_txn(1'b1, 2'b10, 16'h0104, 32'h8765_4321, 50, 1'b0, 32'h0, -1,
              1'b0, 32'h0, 1'b1, 32'h8765_4321);
      // illegal requests
      run_txn(1'b0, 2'b10, 16'h0002, 32'h0, 0, 1'b0, 32'h0, -1,
              1'b1, 32'h0, 1'b0, 32'h0);
      run_txn(1'b1, 2'b11, 16'h0000, 32'h0, 0, 1'b0, 32'h0, -1,
              1'b1, 32'h0, 1'b0, 32'h0);
      // reset during write data phase, then a normal read
      run_txn(1'b1, 2'b10, 16'h0040, 32'h1122_3344, 3, 1'b0, 32'h0, 1,
              1'b0, 32'h0, 1'b0, 32'h0);
      run_txn(1'b0, 2'b10, 16'h0010, 32'h0, 0, 1'b1, 32'hCAFE_F00D, -1,
              1'b1, 32'hCAFE_F00D, 1'b0, 32'h0);

      for (int i = 0; i < 200; i++) begin
         we   = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         addr = 16'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            if (size == 2'd1) addr[0] = 1'b0;
            if (size == 2'd2) addr[1:0] = 2'b00;
         end
         d = int'($urandom_range(0, 6));
         n = (d < T) ? d + 1 : T;
         rst_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         run_txn(we, size, addr, $urandom, d, 1'b0, 32'h0, rst_at,
                 1'b0, 32'h0, 1'b0, 32'h0);
         idle_gap(int'($urandom_range(0, 2)));
      end

      idle_gap(3);
      @(negedge clk_i);
      #1;
      chk("queue_drain", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
